uart_transmitter: RTL and testbench

UART 8-bit serializer, LSB first, optional parity, 1 or 2 stop bits. Companion to the team's UART receiver; drives the TxD pin on the FPGA board. A one-entry holding register allows back-to-back frames with no idle gap. Uses a valid/ready byte handshake toward the cryptography datapath.

---
 rtl/uart_transmitter.sv | 136 +++++++++++++
 tb/tb_uart_transmitter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8-bit UART serializer, LSB first, optional parity, 1/2 stop bits.
// One-entry holding register so a queued byte starts on the edge the previous stop bit ends.
module uart_transmitter #(
  parameter int clk_freq   = 100_000_000,
  parameter int baud_rate  = 9_600,
  parameter int div_bit    = clk_freq / baud_rate,
  parameter bit parity_en  = 1'b0,
  parameter bit parity_odd = 1'b0,
  parameter int stop_bits  = 1
) (
  input  logic       clock_fpga,
  input  logic       reset,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady,
  output logic       TxD,
  output logic       TxBusy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [13:0] baud_max = 14'(div_bit - 1);
  localparam logic [2:0]  stop_max = 3'(stop_bits - 1);

  logic [2:0]  state, state_n;
  logic [13:0] baud_cnt, baud_cnt_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  hold_reg, shifter, shifter_n;
  logic        hold_full, hold_full_n;
  logic        parity_bit, parity_bit_n;
  logic        txd_n;
  logic        accept, drain, bit_end;

  assign accept      = TxValid & TxReady;
  assign bit_end     = (baud_cnt == baud_max);
  assign hold_full_n = accept | (hold_full & ~drain);

  always_comb begin
    state_n      = state;
    baud_cnt_n   = baud_cnt;
    bit_cnt_n    = bit_cnt;
    shifter_n    = shifter;
    parity_bit_n = parity_bit;
    txd_n        = TxD;
    drain        = 1'b0;
    if (state != IDLE) baud_cnt_n = bit_end ? 14'd0 : baud_cnt + 14'd1;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (hold_full) drain = 1'b1;
      end
      START: if (bit_end) begin
        state_n   = DATA;
        bit_cnt_n = 3'd0;
        txd_n     = shifter[0];
      end
      DATA: if (bit_end) begin
        shifter_n = {1'b0, shifter[7:1]};
        if (bit_cnt == 3'd7) begin
          bit_cnt_n = 3'd0;
          if (parity_en) begin
            state_n = PARITY;
            txd_n   = parity_bit;
          end else begin
            state_n = STOP;
            txd_n   = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 3'd1;
          txd_n     = shifter[1];
        end
      end
      PARITY: if (bit_end) begin
        state_n   = STOP;
        bit_cnt_n = 3'd0;
        txd_n     = 1'b1;
      end
      STOP: if (bit_end) begin
        if (bit_cnt == stop_max) begin
          bit_cnt_n = 3'd0;
          if (hold_full) drain = 1'b1;
          else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 3'd1;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
    // Parity is latched from the byte as it leaves the holding register.
    if (drain) begin
      state_n      = START;
      baud_cnt_n   = 14'd0;
      bit_cnt_n    = 3'd0;
      shifter_n    = hold_reg;
      parity_bit_n = (^hold_reg) ^ parity_odd;
      txd_n        = 1'b0;
    end
  end

  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= 14'd0;
      bit_cnt    <= 3'd0;
      shifter    <= 8'd0;
      hold_reg   <= 8'd0;
      hold_full  <= 1'b0;
      parity_bit <= 1'b0;
      TxD        <= 1'b1;
      TxReady    <= 1'b1;
      TxBusy     <= 1'b0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      bit_cnt    <= bit_cnt_n;
      shifter    <= shifter_n;
      parity_bit <= parity_bit_n;
      hold_full  <= hold_full_n;
      if (accept) hold_reg <= TxData;
      TxD        <= txd_n;
      TxReady    <= ~hold_full_n;
      TxBusy     <= (state_n != IDLE) | hold_full_n;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter.
// Four instances: 0 = 8N1, 1 = even parity, 2 = odd parity, 3 = two stop bits; all 16 cycles/bit.
module tb_uart_transmitter;

  localparam int DIV = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] data  [4];
  logic       valid [4];
  logic       ready [4];
  logic       txd   [4];
  logic       busy  [4];

  logic [7:0] sb [4][$];
  int tests_run    = 0;
  int tests_failed = 0;

  int         r_idle  [4];
  logic       r_rdyf  [4];
  logic       r_rdyl  [4];
  logic [7:0] r_got   [4];
  logic       r_par   [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_transmitter #(
      .div_bit   (DIV),
      .parity_en ((g == 1 || g == 2) ? 1'b1 : 1'b0),
      .parity_odd((g == 2) ? 1'b1 : 1'b0),
      .stop_bits ((g == 3) ? 2 : 1)
    ) dut (
      .clock_fpga(clk),
      .reset     (rst_n),
      .TxData    (data[g]),
      .TxValid   (valid[g]),
      .TxReady   (ready[g]),
      .TxD       (txd[g]),
      .TxBusy    (busy[g])
    );
  end

  function automatic int pe(input int i);
    return (i == 1 || i == 2) ? 1 : 0;
  endfunction

  function automatic int st(input int i);
    return (i == 3) ? 2 : 1;
  endfunction

  task automatic send(input int i, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    data[i]  = b;
    valid[i] = 1'b1;
    while (ready[i] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (ready[i] !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_timeout[%0d]: TxReady=%b, required 1 within 1000 cycles", i, ready[i]);
      valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    sb[i].push_back(b);
    #1 valid[i] = 1'b0;
  endtask

  // Receiver model: checks every sample of every bit period and decodes at mid-bit.
  task automatic rx_frame(input int i, output int idle, output logic rdy_first,
                          output logic rdy_last, output logic [7:0] got, output logic par);
    logic [7:0]  exp;
    logic [11:0] bits;
    int          nbits;
    int          bad;
    logic        busy_ok;
    idle = 0; got = 8'h00; par = 1'b0; rdy_first = 1'b0; rdy_last = 1'b0;
    @(negedge clk);
    while (txd[i] !== 1'b0 && idle < 400) begin
      idle++;
      @(negedge clk);
    end
    tests_run++;
    if (txd[i] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_start[%0d]: line=%b, required 0 within 400 cycles", i, txd[i]);
      return;
    end
    rdy_first = ready[i];
    tests_run++;
    if (sb[i].size() == 0) begin
      tests_failed++;
      $display("FAIL rx_unexpected[%0d]: frame seen with 0 bytes queued, required >=1", i);
      exp = 8'h00;
    end else begin
      exp = sb[i].pop_front();
    end
    nbits     = 9 + pe(i) + st(i);
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = exp;
    if (pe(i) != 0) bits[9] = (^exp) ^ (i == 2);
    bad     = 0;
    busy_ok = 1'b1;
    for (int j = 0; j < nbits * DIV; j++) begin
      if (j > 0) @(negedge clk);
      if (txd[i] !== bits[j / DIV]) bad++;
      if (busy[i] !== 1'b1) busy_ok = 1'b0;
      if (j % DIV == DIV / 2) begin
        if (j / DIV >= 1 && j / DIV <= 8) got[j / DIV - 1] = txd[i];
        if (pe(i) != 0 && j / DIV == 9) par = txd[i];
      end
    end
    rdy_last = ready[i];
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL rx_shape[%0d]: %0d samples off for byte %02h, required 0", i, bad, exp);
    end
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL rx_byte[%0d]: got %02h, required %02h", i, got, exp);
    end
    tests_run++;
    if (busy_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL rx_busy[%0d]: TxBusy dropped during frame, required 1", i);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid[i] = 1'b0;
      data[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests_run += 3;
      if (txd[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_txd[%0d]: got %b, required 1", i, txd[i]);
      end
      if (ready[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_ready[%0d]: got %b, required 1", i, ready[i]);
      end
      if (busy[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_busy[%0d]: got %b, required 0", i, busy[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    send(0, 8'h55);
    @(negedge clk);
    tests_run += 3;
    if (txd[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_pre_txd: got %b, required 1", txd[0]);
    end
    if (ready[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_accept_ready: got %b, required 0", ready[0]);
    end
    if (busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_accept_busy: got %b, required 1", busy[0]);
    end
    rx_frame(0, r_idle[0], r_rdyf[0], r_rdyl[0], r_got[0], r_par[0]);
    tests_run += 2;
    if (r_idle[0] != 0) begin
      tests_failed++;
      $display("FAIL single_latency: start %0d cycles late, required 0", r_idle[0]);
    end
    if (r_rdyf[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ready_back: got %b, required 1", r_rdyf[0]);
    end
    @(negedge clk);
    tests_run += 3;
    if (txd[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_end_txd: got %b, required 1", txd[0]);
    end
    if (busy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_end_busy: got %b, required 0", busy[0]);
    end
    if (ready[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_end_ready: got %b, required 1", ready[0]);
    end
  endtask

  task automatic test_back_to_back();
    int         idl [2];
    logic       rf  [2];
    logic       rl  [2];
    logic [7:0] gb  [2];
    logic       pb  [2];
    fork
      begin
        send(0, 8'hA5);
        send(0, 8'h3C);
      end
      begin
        for (int k = 0; k < 2; k++) rx_frame(0, idl[k], rf[k], rl[k], gb[k], pb[k]);
      end
    join
    tests_run += 3;
    if (rl[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_ready_held: TxReady=%b at end of first frame, required 0", rl[0]);
    end
    if (idl[1] != 0) begin
      tests_failed++;
      $display("FAIL b2b_gap: %0d idle cycles, required 0", idl[1]);
    end
    if (rf[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready_drain: got %b, required 1", rf[1]);
    end
  endtask

  task automatic test_parity();
    send(1, 8'h07);
    rx_frame(1, r_idle[1], r_rdyf[1], r_rdyl[1], r_got[1], r_par[1]);
    send(2, 8'h07);
    rx_frame(2, r_idle[2], r_rdyf[2], r_rdyl[2], r_got[2], r_par[2]);
    tests_run += 2;
    if (r_par[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_even: got %b, required 1", r_par[1]);
    end
    if (r_par[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_odd: got %b, required 0", r_par[2]);
    end
    @(negedge clk);
    tests_run++;
    if (busy[2] !== 1'b0 || txd[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_len: busy=%b txd=%b after 11 bits, required busy=0 txd=1", busy[2], txd[2]);
    end
  endtask

  task automatic test_two_stop();
    int         idl [2];
    logic       rf  [2];
    logic       rl  [2];
    logic [7:0] gb  [2];
    logic       pb  [2];
    fork
      begin
        send(3, 8'hFF);
        send(3, 8'h00);
      end
      begin
        for (int k = 0; k < 2; k++) rx_frame(3, idl[k], rf[k], rl[k], gb[k], pb[k]);
      end
    join
    tests_run++;
    if (idl[1] != 0) begin
      tests_failed++;
      $display("FAIL stop2_gap: %0d idle cycles after two stop bits, required 0", idl[1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    send(0, 8'h00);
    repeat (73) @(negedge clk);
    tests_run++;
    if (txd[0] !== 1'b0 || busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_pre: txd=%b busy=%b in data bit 3, required txd=0 busy=1", txd[0], busy[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run += 3;
    if (txd[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_txd: got %b, required 1", txd[0]);
    end
    if (ready[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_ready: got %b, required 1", ready[0]);
    end
    if (busy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy: got %b, required 0", busy[0]);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sb[0].delete();
    send(0, 8'h81);
    rx_frame(0, r_idle[0], r_rdyf[0], r_rdyl[0], r_got[0], r_par[0]);
    tests_run++;
    if (r_got[0] !== 8'h81 || r_idle[0] != 1) begin
      tests_failed++;
      $display("FAIL abort_clean: got %02h idle %0d, required 81 idle 1", r_got[0], r_idle[0]);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] msg [4];
    int         idl [4];
    logic       rf  [4];
    logic       rl  [4];
    logic [7:0] gb  [4];
    logic       pb  [4];
    msg[0] = 8'h00; msg[1] = 8'hFF; msg[2] = 8'h5A; msg[3] = 8'hC3;
    fork
      begin
        for (int k = 0; k < 4; k++) send(0, msg[k]);
      end
      begin
        for (int k = 0; k < 4; k++) rx_frame(0, idl[k], rf[k], rl[k], gb[k], pb[k]);
      end
    join
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (gb[k] !== msg[k]) begin
        tests_failed++;
        $display("FAIL loop_byte[%0d]: got %02h, required %02h", k, gb[k], msg[k]);
      end
    end
    for (int k = 1; k < 4; k++) begin
      tests_run++;
      if (idl[k] != 0) begin
        tests_failed++;
        $display("FAIL loop_gap[%0d]: %0d idle cycles, required 0", k, idl[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_reset_mid_frame();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded 1000000 time units, required completion");
    $fatal(1);
  end

endmodule
